branch_predictor: RTL and testbench

- Fetch-side bimodal branch predictor: a table of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- Sits directly upstream of the branch manager and supplies its pred_taken, pred_pc and pred_addr inputs, one cycle after fetch presents a PC.
- Trained by the execute stage's resolved-branch update port.

---
 rtl/branch_pkg.sv | 41 ++++
 rtl/bp_counter_table.sv | 35 +++
 rtl/branch_predictor.sv | 107 ++++++++++
 tb/tb_branch_predictor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the fetch-side branch predictor: counter encoding, BTB entry, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package branch_pkg;

  localparam int BP_WORD_SIZE  = 32;
  localparam int BP_INDEX_BITS = 6;
  localparam int BP_TAG_BITS   = BP_WORD_SIZE - BP_INDEX_BITS - 2;

  // 2-bit saturating direction counter; bit 1 is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_ctr_t;

  localparam bp_ctr_t BP_RESET_CTR = WNT;

  // One direct-mapped BTB line, sized by the package widths
  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_BITS-1:0]  tag;
    logic [BP_WORD_SIZE-1:0] target;
  } btb_entry_t;

  // Move a counter one step toward the resolved direction, saturating at both ends
  function automatic bp_ctr_t sat_step(input bp_ctr_t c, input logic taken);
    bp_ctr_t r;
    r = c;
    case (c)
      SNT: r = taken ? WNT : SNT;
      WNT: r = taken ? WT  : SNT;
      WT:  r = taken ? ST  : WNT;
      ST:  r = taken ? ST  : WT;
      default: r = BP_RESET_CTR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating direction counters with one comb read and one write port.
// Latency: read is combinational; a write is visible from the next cycle (read-before-write).
// Backpressure: none; a write is accepted every cycle wr_en is high.
module bp_counter_table
  import branch_pkg::*;
#(
  parameter int IndexBits = BP_INDEX_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IndexBits-1:0] rd_idx,
  output bp_ctr_t              rd_ctr,
  input  logic                 wr_en,
  input  logic [IndexBits-1:0] wr_idx,
  input  logic                 wr_taken
);

  localparam int Depth = 1 << IndexBits;

  bp_ctr_t ctr_q [Depth];

  assign rd_ctr = ctr_q[rd_idx];

  // Train the addressed counter; every counter restarts weakly not-taken
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < Depth; i++) begin
        ctr_q[i] <= BP_RESET_CTR;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= sat_step(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal direction predictor plus direct-mapped BTB; gshare indexing with BRANCH_PREDICTOR_GSHARE_EN.
// Latency: 1 cycle from fetch_pc to pred_taken/pred_pc/pred_addr; updates visible next cycle.
// Backpressure: none; predicts every cycle and accepts an update every cycle.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int WordSize  = BP_WORD_SIZE,
  parameter int IndexBits = BP_INDEX_BITS
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WordSize-1:0] fetch_pc,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_pc,
  output logic [WordSize-1:0] pred_addr,
  input  logic                upd_en,
  input  logic [WordSize-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [WordSize-1:0] upd_target
);

  localparam int Depth = 1 << IndexBits;
  localparam logic [WordSize-1:0] PcStep = WordSize'(4);

  logic [IndexBits-1:0]          fetch_idx, upd_idx;
  logic [WordSize-IndexBits-3:0] fetch_tag, upd_tag;
  logic [IndexBits-1:0]          ctr_rd_idx, ctr_wr_idx;
  bp_ctr_t                       ctr_rd;
  btb_entry_t                    btb_q [Depth];
  btb_entry_t                    btb_rd;
  logic                          hit;
  logic                          taken_nxt;
  logic [WordSize-1:0]           addr_nxt;
  logic                          unused_pc_lsbs;

  // Instruction-aligned PCs: the two low bits carry no information
  assign unused_pc_lsbs = &{1'b0, fetch_pc[1:0], upd_pc[1:0]};

  assign fetch_idx = fetch_pc[IndexBits+1:2];
  assign fetch_tag = fetch_pc[WordSize-1:IndexBits+2];
  assign upd_idx   = upd_pc[IndexBits+1:2];
  assign upd_tag   = upd_pc[WordSize-1:IndexBits+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IndexBits-1:0] ghr;

  // Global history shifts in each resolved direction; lookup and update see the pre-shift value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr <= '0;
    end else if (upd_en) begin
      ghr <= {ghr[IndexBits-2:0], upd_taken};
    end
  end

  assign ctr_rd_idx = fetch_idx ^ ghr;
  assign ctr_wr_idx = upd_idx ^ ghr;
`else
  assign ctr_rd_idx = fetch_idx;
  assign ctr_wr_idx = upd_idx;
`endif

  bp_counter_table #(
    .IndexBits (IndexBits)
  ) u_ctr (
    .clk      (clk),
    .rstn     (rstn),
    .rd_idx   (ctr_rd_idx),
    .rd_ctr   (ctr_rd),
    .wr_en    (upd_en),
    .wr_idx   (ctr_wr_idx),
    .wr_taken (upd_taken)
  );

  // Lookup: a BTB miss forces not-taken whatever the counter says
  always_comb begin
    btb_rd    = btb_q[fetch_idx];
    hit       = btb_rd.valid && (btb_rd.tag == fetch_tag);
    taken_nxt = hit && ctr_rd[1];
    addr_nxt  = taken_nxt ? btb_rd.target : fetch_pc + PcStep;
  end

  // Register the prediction for the fetch PC presented this cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_taken <= 1'b0;
      pred_pc    <= '0;
      pred_addr  <= '0;
    end else begin
      pred_taken <= taken_nxt;
      pred_pc    <= fetch_pc;
      pred_addr  <= addr_nxt;
    end
  end

  // BTB learns only from taken branches; aliases are simply overwritten
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < Depth; i++) begin
        btb_q[i] <= '0;
      end
    end else if (upd_en && upd_taken) begin
      btb_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Latency: checks outputs 1 ns after the edge that registered them.
// Backpressure: n/a.
module tb_branch_predictor;

  localparam int W  = 32;
  localparam int IB = 6;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] fetch_pc;
  logic         pred_taken;
  logic [W-1:0] pred_pc;
  logic [W-1:0] pred_addr;
  logic         upd_en;
  logic [W-1:0] upd_pc;
  logic         upd_taken;
  logic [W-1:0] upd_target;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(
    .WordSize  (W),
    .IndexBits (IB)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fetch_pc   (fetch_pc),
    .pred_taken (pred_taken),
    .pred_pc    (pred_pc),
    .pred_addr  (pred_addr),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic en, input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt);
    upd_en     = en;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    fetch_pc = 32'h100;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    #3;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", pred_pc); end
    n_cmp++; if (pred_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", pred_addr); end
    step();
    step();
    rstn = 1'b1;
    step();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL first_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_pc !== 32'h100) begin n_err++; $display("FAIL first_pc got=%h exp=100", pred_pc); end
    n_cmp++; if (pred_addr !== 32'h104) begin n_err++; $display("FAIL first_addr got=%h exp=104", pred_addr); end
  endtask

  task automatic test_train();
    fetch_pc = 32'h400;
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    step();
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_pc = 32'h100;
    step();
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL train_taken got=%0b exp=1", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h200) begin n_err++; $display("FAIL train_addr got=%h exp=200", pred_addr); end
  endtask

  task automatic test_saturation();
    fetch_pc = 32'h400;
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    repeat (5) step();
    upd_taken = 1'b0;
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_pc = 32'h100;
    step();
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_wt_taken got=%0b exp=1", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h200) begin n_err++; $display("FAIL sat_wt_addr got=%h exp=200", pred_addr); end
    fetch_pc = 32'h400;
    set_upd(1'b1, 32'h100, 1'b0, 32'h0);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_pc = 32'h100;
    step();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_wnt_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h104) begin n_err++; $display("FAIL sat_wnt_addr got=%h exp=104", pred_addr); end
  endtask

  task automatic test_alias();
    fetch_pc = 32'h400;
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_pc = 32'h100 + (32'h1 << (IB + 2));
    step();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h204) begin n_err++; $display("FAIL alias_addr got=%h exp=204", pred_addr); end
    fetch_pc = 32'h100;
    step();
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_owner_taken got=%0b exp=1", pred_taken); end
    fetch_pc = 32'h400;
    set_upd(1'b1, 32'h200, 1'b1, 32'h300);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_pc = 32'h100;
    step();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL evicted_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h104) begin n_err++; $display("FAIL evicted_addr got=%h exp=104", pred_addr); end
    fetch_pc = 32'h200;
    step();
    n_cmp++; if (pred_addr !== 32'h300) begin n_err++; $display("FAIL new_owner_addr got=%h exp=300", pred_addr); end
  endtask

  task automatic test_same_cycle();
    // Leave index 0 at WNT with a valid 0x100 entry; not-taken updates must keep the BTB line
    fetch_pc = 32'h400;
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    step();
    upd_taken = 1'b0;
    step();
    step();
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    fetch_pc = 32'h100;
    step();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rbw_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h104) begin n_err++; $display("FAIL rbw_addr got=%h exp=104", pred_addr); end
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_pc = 32'h102;
    step();
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL after_rbw_taken got=%0b exp=1", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h200) begin n_err++; $display("FAIL after_rbw_addr got=%h exp=200", pred_addr); end
    n_cmp++; if (pred_pc !== 32'h102) begin n_err++; $display("FAIL after_rbw_pc got=%h exp=102", pred_pc); end
  endtask

  task automatic test_wrap();
    fetch_pc = 32'hFFFF_FFFC;
    step();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL wrap_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got=%h exp=0", pred_addr); end
  endtask

  task automatic test_mid_reset();
    fetch_pc = 32'h100;
    step();
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL pre_reset_taken got=%0b exp=1", pred_taken); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL async_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_pc !== 32'h0) begin n_err++; $display("FAIL async_pc got=%h exp=0", pred_pc); end
    n_cmp++; if (pred_addr !== 32'h0) begin n_err++; $display("FAIL async_addr got=%h exp=0", pred_addr); end
    step();
    rstn = 1'b1;
    step();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL post_reset_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h104) begin n_err++; $display("FAIL post_reset_addr got=%h exp=104", pred_addr); end
    n_cmp++; if (pred_pc !== 32'h100) begin n_err++; $display("FAIL post_reset_pc got=%h exp=100", pred_pc); end
  endtask

  task automatic test_gshare();
    // After one taken update ghr=1, so 0x100 looks up counter 1 (still WNT) instead of counter 0 (WT)
    fetch_pc = 32'h400;
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_pc = 32'h100;
    step();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL gshare_taken got=%0b exp=0", pred_taken); end
    n_cmp++; if (pred_addr !== 32'h104) begin n_err++; $display("FAIL gshare_addr got=%h exp=104", pred_addr); end
  endtask

  initial begin
    test_reset();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    test_gshare();
`else
    test_train();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_mid_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
